switches: RTL and testbench

- Memory-mapped input peripheral for the board DIP switches; the read-side counterpart of the LED output block.
- Synchronizes and debounces the raw switch pins, holding a stable switch image and a sticky "changed" flag.
- Returns either value on a CPU/memorio read, with a registered read-data port.
- Sits on the same I/O decode as the LED block: chip-select plus a 2-bit register address.

---
 rtl/switches_if.sv | 22 ++
 rtl/switches.sv | 101 ++++++++++
 tb/tb_switches.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/switches_if.sv
// CPU/memorio read bus for the DIP switch peripheral: chip-select, read strobe,
// register address and the registered read data returned by the block.
interface switches_if;
  logic        switchread;
  logic        switchcs;
  logic [1:0]  switchaddr;
  logic [31:0] switchrdata;

  modport master (
    output switchread,
    output switchcs,
    output switchaddr,
    input  switchrdata
  );

  modport slave (
    input  switchread,
    input  switchcs,
    input  switchaddr,
    output switchrdata
  );
endinterface

// File: rtl/switches.sv
// DIP switch input peripheral: 2-flop synchronizer, whole-vector debounce,
// sticky read-to-clear change flag and a registered memory-mapped read port.
module switches #(
  parameter int SW_WIDTH        = 24,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                switch_clk,
  input  logic                switchrst_n,
  input  logic [SW_WIDTH-1:0] switch_i,
  switches_if.slave           bus
);

  localparam int               CNT_W       = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [1:0]       ADDR_IMAGE  = 2'b00;
  localparam logic [1:0]       ADDR_STATUS = 2'b10;

  logic [SW_WIDTH-1:0] r_sync1;
  logic [SW_WIDTH-1:0] r_sync2;
  logic [SW_WIDTH-1:0] r_cand;
  logic [CNT_W-1:0]    r_cnt;
  logic [SW_WIDTH-1:0] r_stable;
  logic                r_changed;
  logic [31:0]         r_rdata;

  logic                w_cand_differs;
  logic                w_settled;
  logic                w_update;
  logic                w_rd_acc;
  logic                w_rd_status;
  logic [31:0]         w_rdata_nxt;

  // The candidate is accepted only once the counter has saturated with the
  // synchronized input still matching it.
  assign w_cand_differs = (r_sync2 != r_cand);
  assign w_settled      = !w_cand_differs && (r_cnt == CNT_MAX);
  assign w_update       = w_settled && (r_cand != r_stable);
  assign w_rd_acc       = bus.switchcs && bus.switchread;
  assign w_rd_status    = w_rd_acc && (bus.switchaddr == ADDR_STATUS);

  always_comb begin
    w_rdata_nxt = 32'h0;
    case (bus.switchaddr)
      ADDR_IMAGE:  w_rdata_nxt = 32'(r_stable);
      ADDR_STATUS: w_rdata_nxt = {31'h0, r_changed};
      default:     w_rdata_nxt = 32'h0;
    endcase
  end

  always_ff @(posedge switch_clk or negedge switchrst_n) begin
    if (!switchrst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switch_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge switch_clk or negedge switchrst_n) begin
    if (!switchrst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (w_cand_differs) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt < CNT_MAX) begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge switch_clk or negedge switchrst_n) begin
    if (!switchrst_n) begin
      r_stable <= '0;
    end else if (w_update) begin
      r_stable <= r_cand;
    end
  end

  // A new acceptance outranks a status read on the same edge so no event is lost.
  always_ff @(posedge switch_clk or negedge switchrst_n) begin
    if (!switchrst_n) begin
      r_changed <= 1'b0;
    end else if (w_update) begin
      r_changed <= 1'b1;
    end else if (w_rd_status) begin
      r_changed <= 1'b0;
    end
  end

  always_ff @(posedge switch_clk or negedge switchrst_n) begin
    if (!switchrst_n) begin
      r_rdata <= 32'h0;
    end else if (w_rd_acc) begin
      r_rdata <= w_rdata_nxt;
    end
  end

  assign bus.switchrdata = r_rdata;

endmodule

// File: tb/tb_switches.sv
// Scoreboard bench for the switches peripheral with DEBOUNCE_CYCLES = 4.
module tb_switches;

  localparam int SW_WIDTH = 24;
  localparam int DEB      = 4;

  logic                switch_clk;
  logic                switchrst_n;
  logic [SW_WIDTH-1:0] switch_i;

  switches_if bus();

  switches #(
    .SW_WIDTH        (SW_WIDTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .switch_clk  (switch_clk),
    .switchrst_n (switchrst_n),
    .switch_i    (switch_i),
    .bus         (bus)
  );

  initial switch_clk = 1'b0;
  always #5 switch_clk = ~switch_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  string       nm_q[$];
  logic [31:0] got;
  logic [31:0] exp;
  string       nm;

  task automatic tick();
    @(posedge switch_clk);
    @(negedge switch_clk);
  endtask

  task automatic drive(input logic cs, input logic rd, input logic [1:0] a,
                       input logic [31:0] e, input string name);
    bus.switchcs   = cs;
    bus.switchread = rd;
    bus.switchaddr = a;
    sb_q.push_back(e);
    nm_q.push_back(name);
  endtask

  task automatic idle(input int n);
    bus.switchcs   = 1'b0;
    bus.switchread = 1'b0;
    bus.switchaddr = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    switchrst_n    = 1'b0;
    switch_i       = '0;
    bus.switchcs   = 1'b0;
    bus.switchread = 1'b0;
    bus.switchaddr = 2'b00;
    @(negedge switch_clk);
    drive(1'b0, 1'b0, 2'b00, 32'h0, "reset_state");
    got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    switchrst_n = 1'b1;
    switch_i = 24'hFFFFFF;
    idle(10);
    drive(1'b1, 1'b1, 2'b00, 32'h00FFFFFF, "pre_reset_image");
    tick();
    got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    bus.switchcs = 1'b0; bus.switchread = 1'b0;
    #2 switchrst_n = 1'b0;
    #1 drive(1'b0, 1'b0, 2'b00, 32'h0, "async_reset_clear");
    got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    @(negedge switch_clk);
    switchrst_n = 1'b1;
    // Edge 1 after release is the first to sample the held level.
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) drive(1'b1, 1'b1, 2'b10, 32'h0, "post_reset_status");
      else drive(1'b1, 1'b1, 2'b00, (k <= DEB + 4) ? 32'h0 : 32'h00FFFFFF, $sformatf("post_reset_read_%0d", k));
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 2'b10, (k == 0) ? 32'h1 : 32'h0, $sformatf("post_reset_changed_%0d", k));
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
  endtask

  task automatic test_clean_step();
    switch_i = '0;
    idle(12);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive(1'b1, 1'b1, 2'b10, 32'h1, "step_prep_status");
      else drive(1'b1, 1'b1, 2'b00, 32'h0, "step_prep_image");
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
    switch_i = 24'hA5A5A5;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 10) drive(1'b1, 1'b1, 2'b00, (k <= DEB + 4) ? 32'h0 : 32'h00A5A5A5, $sformatf("step_read_%0d", k));
      else drive(1'b1, 1'b1, 2'b10, (k == 11) ? 32'h1 : 32'h0, $sformatf("step_status_%0d", k));
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
  endtask

  task automatic test_glitch();
    switch_i = '0;
    idle(12);
    drive(1'b1, 1'b1, 2'b10, 32'h1, "glitch_prep_status");
    tick();
    got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    switch_i = 24'h000001;
    idle(3);
    switch_i = '0;
    idle(12);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, (k == 0) ? 2'b00 : 2'b10, 32'h0, (k == 0) ? "glitch_image" : "glitch_status");
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
  endtask

  task automatic test_glitch_extended();
    // Six input samples give the synchronized side DEB+2 matching samples: load plus full count plus accept.
    for (int k = 1; k <= 9; k++) begin
      switch_i = (k <= 6) ? 24'h000001 : 24'h000000;
      drive(1'b1, 1'b1, 2'b00, (k <= DEB + 4) ? 32'h0 : 32'h1, $sformatf("long_pulse_read_%0d", k));
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
    idle(12);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) drive(1'b1, 1'b1, 2'b00, 32'h0, "long_pulse_fall_image");
      else drive(1'b1, 1'b1, 2'b10, (k == 0) ? 32'h1 : 32'h0, $sformatf("long_pulse_status_%0d", k));
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 20; k++) begin
      switch_i = ((k / 2) % 2 == 0) ? 24'h000080 : 24'h000000;
      drive(1'b1, 1'b1, 2'b00, 32'h0, $sformatf("bounce_hold_old_%0d", k));
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
    switch_i = 24'h000080;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b1, 2'b00, (k <= DEB + 4) ? 32'h0 : 32'h80, $sformatf("bounce_settle_%0d", k));
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 2'b10, (k == 0) ? 32'h1 : 32'h0, $sformatf("bounce_status_%0d", k));
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
  endtask

  task automatic test_read_side();
    switch_i = 24'h000081;
    idle(DEB + 3);
    // Edge DEB+4 both accepts the new image and samples this status read.
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: drive(1'b1, 1'b1, 2'b10, 32'h0,  "status_same_edge");
        1: drive(1'b1, 1'b1, 2'b00, 32'h81, "image_after_update");
        2: drive(1'b0, 1'b1, 2'b10, 32'h81, "cs_low_holds");
        3: drive(1'b1, 1'b0, 2'b10, 32'h81, "read_low_holds");
        4: drive(1'b1, 1'b1, 2'b01, 32'h0,  "reserved_01");
        5: drive(1'b1, 1'b1, 2'b11, 32'h0,  "reserved_11");
        6: drive(1'b1, 1'b1, 2'b10, 32'h1,  "changed_kept");
        default: drive(1'b1, 1'b1, 2'b10, 32'h0, "changed_cleared");
      endcase
      tick();
      got = bus.switchrdata; exp = sb_q.pop_front(); nm = nm_q.pop_front(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_glitch_extended();
    test_bounce();
    test_read_side();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
